// File: rtl/up_down_counter.sv
// Modulo-N up/down counter with load, synchronous clear, wrap or saturate at the
// boundary, a combinational cascade carry, a one-cycle wrap pulse and a sticky overflow flag.
module up_down_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MODULUS  = 64'd1 << WIDTH,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clock_i,
    input  logic             clear_i,
    input  logic             sync_clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             enable_i,
    input  logic             up_down_i,
    input  logic             clear_flags_i,
    output logic [WIDTH-1:0] count_o,
    output logic             carry_out_o,
    output logic             wrap_pulse_o,
    output logic             overflow_o
);

    // Top count is formed in 64 bits so MODULUS = 2**WIDTH never overflows.
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             overflow_q, overflow_d;
    logic             at_bound;
    logic             boundary;

    assign at_bound = up_down_i ? (count_q == MaxVal) : (count_q == '0);
    assign boundary = !sync_clear_i && !load_i && enable_i && at_bound;

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        overflow_d = overflow_q;

        if (sync_clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = (load_value_i > MaxVal) ? MaxVal : load_value_i;
        end else if (enable_i) begin
            if (at_bound) begin
                if (!SATURATE) begin
                    count_d = up_down_i ? '0 : MaxVal;
                end
            end else begin
                count_d = up_down_i ? (count_q + One) : (count_q - One);
            end
        end

        // A boundary event wins over clear_flags on the same edge.
        if (boundary) begin
            wrap_d     = 1'b1;
            overflow_d = 1'b1;
        end else if (clear_flags_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge clear_i) begin
        if (clear_i) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o      = count_q;
    assign carry_out_o  = enable_i & at_bound;
    assign wrap_pulse_o = wrap_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_up_down_counter.sv
// Bench for up_down_counter: wrapping, saturating and cascaded instances checked every
// cycle against an arithmetic model, plus hand-computed directed expectations.
module tb_up_down_counter;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       sc = 1'b0, ld = 1'b0, en = 1'b0, ud = 1'b0, cf = 1'b0, en_ch = 1'b0;
    logic [7:0] lv = 8'd0;
    logic       chk_on = 1'b0;

    logic [7:0] cnt_a;
    logic [3:0] cnt_b, cnt_c, cnt_lo, cnt_hi;
    logic       car_a, car_b, car_c, car_lo, car_hi;
    logic       wr_a, wr_b, wr_c, wr_lo, wr_hi;
    logic       of_a, of_b, of_c, of_lo, of_hi;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    up_down_counter u_a (
        .clock_i(clk), .clear_i(clear), .sync_clear_i(sc), .load_i(ld), .load_value_i(lv),
        .enable_i(en), .up_down_i(ud), .clear_flags_i(cf), .count_o(cnt_a),
        .carry_out_o(car_a), .wrap_pulse_o(wr_a), .overflow_o(of_a)
    );

    up_down_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
        .clock_i(clk), .clear_i(clear), .sync_clear_i(sc), .load_i(ld),
        .load_value_i(lv[3:0]), .enable_i(en), .up_down_i(ud), .clear_flags_i(cf),
        .count_o(cnt_b), .carry_out_o(car_b), .wrap_pulse_o(wr_b), .overflow_o(of_b)
    );

    up_down_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_c (
        .clock_i(clk), .clear_i(clear), .sync_clear_i(sc), .load_i(ld),
        .load_value_i(lv[3:0]), .enable_i(en), .up_down_i(ud), .clear_flags_i(cf),
        .count_o(cnt_c), .carry_out_o(car_c), .wrap_pulse_o(wr_c), .overflow_o(of_c)
    );

    up_down_counter #(.WIDTH(4)) u_lo (
        .clock_i(clk), .clear_i(clear), .sync_clear_i(1'b0), .load_i(1'b0),
        .load_value_i(4'd0), .enable_i(en_ch), .up_down_i(1'b1), .clear_flags_i(1'b0),
        .count_o(cnt_lo), .carry_out_o(car_lo), .wrap_pulse_o(wr_lo), .overflow_o(of_lo)
    );

    up_down_counter #(.WIDTH(4)) u_hi (
        .clock_i(clk), .clear_i(clear), .sync_clear_i(1'b0), .load_i(1'b0),
        .load_value_i(4'd0), .enable_i(car_lo), .up_down_i(1'b1), .clear_flags_i(1'b0),
        .count_o(cnt_hi), .carry_out_o(car_hi), .wrap_pulse_o(wr_hi), .overflow_o(of_hi)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit is_event(int m, int c, bit s, bit l, bit e, bit u);
        return !s && !l && e && (u ? (c == m - 1) : (c == 0));
    endfunction

    function automatic int next_cnt(int m, bit sat, int c, bit s, bit l, int v, bit e, bit u);
        if (s) return 0;
        if (l) return (v < m) ? v : m - 1;
        if (!e) return c;
        if (u) return (c == m - 1) ? (sat ? c : 0) : c + 1;
        return (c == 0) ? (sat ? c : m - 1) : c - 1;
    endfunction

    int ma = 0, mb = 0, mc = 0, tot = 0;
    bit wa = 0, wb = 0, wc = 0, wl = 0, wh = 0;
    bit oa = 0, ob = 0, oc = 0, ol = 0, oh = 0;

    always @(posedge clk or posedge clear) begin
        if (clear) begin
            ma <= 0; mb <= 0; mc <= 0; tot <= 0;
            wa <= 0; wb <= 0; wc <= 0; wl <= 0; wh <= 0;
            oa <= 0; ob <= 0; oc <= 0; ol <= 0; oh <= 0;
        end else begin
            ma <= next_cnt(256, 0, ma, sc, ld, int'(lv), en, ud);
            mb <= next_cnt(10, 0, mb, sc, ld, int'(lv[3:0]), en, ud);
            mc <= next_cnt(10, 1, mc, sc, ld, int'(lv[3:0]), en, ud);
            wa <= is_event(256, ma, sc, ld, en, ud);
            wb <= is_event(10, mb, sc, ld, en, ud);
            wc <= is_event(10, mc, sc, ld, en, ud);
            oa <= is_event(256, ma, sc, ld, en, ud) ? 1'b1 : (cf ? 1'b0 : oa);
            ob <= is_event(10, mb, sc, ld, en, ud) ? 1'b1 : (cf ? 1'b0 : ob);
            oc <= is_event(10, mc, sc, ld, en, ud) ? 1'b1 : (cf ? 1'b0 : oc);
            // Cascade viewed as one 8-bit counter.
            if (en_ch) tot <= (tot + 1) % 256;
            wl <= en_ch && (tot % 16 == 15);
            wh <= en_ch && (tot == 255);
            if (en_ch && (tot % 16 == 15)) ol <= 1'b1;
            if (en_ch && (tot == 255)) oh <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a.count", cnt_a, ma);
            chk("a.wrap", wr_a, wa);
            chk("a.ovf", of_a, oa);
            chk("a.carry", car_a, en && (ud ? ma == 255 : ma == 0));
            chk("b.count", cnt_b, mb);
            chk("b.wrap", wr_b, wb);
            chk("b.ovf", of_b, ob);
            chk("b.carry", car_b, en && (ud ? mb == 9 : mb == 0));
            chk("c.count", cnt_c, mc);
            chk("c.wrap", wr_c, wc);
            chk("c.ovf", of_c, oc);
            chk("c.carry", car_c, en && (ud ? mc == 9 : mc == 0));
            chk("chain.value", {cnt_hi, cnt_lo}, tot);
            chk("chain.carry_lo", car_lo, en_ch && (tot % 16 == 15));
            chk("chain.carry_hi", car_hi, en_ch && (tot == 255));
            chk("chain.wrap", {wr_hi, wr_lo}, {wh, wl});
            chk("chain.ovf", {of_hi, of_lo}, {oh, ol});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit l, input logic [7:0] v, input bit e,
                         input bit u, input bit f);
        sc = s; ld = l; lv = v; en = e; ud = u; cf = f;
    endtask

    int exp_c[5] = '{8, 9, 9, 9, 9};
    bit exp_w[5] = '{0, 0, 1, 1, 1};

    initial begin
        #1 clear = 1'b1;
        #1 chk_on = 1'b1;
        cyc(1);
        chk("reset.count", cnt_a, 0);
        chk("reset.wrap", wr_a, 0);
        chk("reset.ovf", of_a, 0);
        clear = 1'b0;

        // Full-range up count with wrap.
        drive(0, 0, 8'd0, 1, 1, 0);
        cyc(255);
        chk("up255.count", cnt_a, 255);
        chk("up255.carry", car_a, 1);
        chk("up255.wrap", wr_a, 0);
        cyc(1);
        chk("up256.count", cnt_a, 0);
        chk("up256.wrap", wr_a, 1);
        chk("up256.ovf", of_a, 1);

        // Sync clear with clear_flags, then count down through 0 on modulus 10.
        drive(1, 0, 8'd0, 0, 0, 1);
        cyc(1);
        chk("sclr.count_b", cnt_b, 0);
        chk("sclr.ovf_b", of_b, 0);
        drive(0, 0, 8'd0, 1, 0, 0);
        cyc(1);
        chk("down1.count_b", cnt_b, 9);
        chk("down1.wrap_b", wr_b, 1);
        cyc(10);
        chk("down11.count_b", cnt_b, 9);
        chk("down11.wrap_b", wr_b, 1);
        chk("down11.count_a", cnt_a, 245);
        drive(0, 0, 8'd0, 0, 0, 1);
        cyc(1);
        chk("cflags.ovf_b", of_b, 0);

        // Saturating count from 7.
        drive(0, 1, 8'd7, 0, 1, 0);
        cyc(1);
        chk("load7.count_c", cnt_c, 7);
        drive(0, 0, 8'd0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("sat.count_c", cnt_c, exp_c[i]);
            chk("sat.wrap_c", wr_c, exp_w[i]);
        end
        chk("sat.ovf_c", of_c, 1);

        // Priority.
        drive(1, 1, 8'd5, 1, 1, 0);
        cyc(1);
        chk("prio.sclr_a", cnt_a, 0);
        chk("prio.sclr_c", cnt_c, 0);
        drive(0, 1, 8'd12, 1, 1, 0);
        cyc(1);
        chk("prio.clamp_c", cnt_c, 9);
        chk("prio.load_a", cnt_a, 12);

        // Cascade of two 4-bit stages.
        drive(0, 0, 8'd0, 0, 1, 0);
        en_ch = 1'b1;
        cyc(300);
        chk("chain300.hi", cnt_hi, 2);
        chk("chain300.lo", cnt_lo, 12);
        en_ch = 1'b0;

        // Asynchronous clear between edges.
        drive(0, 1, 8'h5A, 0, 1, 0);
        cyc(1);
        chk("load5a.count_a", cnt_a, 90);
        chk("load10.clamp_b", cnt_b, 9);
        drive(0, 0, 8'd0, 0, 1, 0);
        #2 clear = 1'b1;
        #1;
        chk("aclr.count_a", cnt_a, 0);
        chk("aclr.ovf_a", of_a, 0);
        chk("aclr.chain", {cnt_hi, cnt_lo}, 0);
        #2 clear = 1'b0;

        // Boundary event and clear_flags together: set wins.
        drive(0, 0, 8'd0, 1, 0, 1);
        cyc(1);
        chk("setwins.count_a", cnt_a, 255);
        chk("setwins.ovf_a", of_a, 1);
        drive(0, 0, 8'd0, 0, 0, 1);
        cyc(1);
        chk("cfonly.ovf_a", of_a, 0);
        chk("cfonly.wrap_a", wr_a, 0);

        drive(0, 0, 8'd0, 0, 0, 0);
        cyc(2);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
